// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and helpers for the ring phase checker
package ring_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_ORDER  = 2'b10;

    localparam logic [3:0] RING_HOME = 4'b0001;

    function automatic logic [3:0] rotl4(input logic [3:0] x);
        return {x[2:0], x[3]};
    endfunction

    function automatic logic is_onehot4(input logic [3:0] x);
        return (x != 4'b0000) && ((x & (x - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/onehot4_enc.sv
// rtl/onehot4_enc.sv - 4-bit one-hot to 2-bit index encoder with valid flag
module onehot4_enc (
    input  logic [3:0] onehot_i,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = 2'd0;
        valid_o = 1'b1;
        case (onehot_i)
            4'b0001: idx_o = 2'd0;
            4'b0010: idx_o = 2'd1;
            4'b0100: idx_o = 2'd2;
            4'b1000: idx_o = 2'd3;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ring_phase_checker.sv
// rtl/ring_phase_checker.sv - lock/phase/rotation monitor for a 4-bit one-hot ring
module ring_phase_checker
    import ring_pkg::*;
#(
    parameter int ROT_W      = 8,
    parameter int LOCK_STEPS = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       RING,
    input  logic             CLR_ERR,
    output logic             LOCKED,
    output logic [1:0]       PHASE,
    output logic [ROT_W-1:0] ROT_CNT,
    output logic             ROT_PULSE,
    output logic             ERR_STICKY,
    output logic [1:0]       ERR_CODE
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_STEPS - 1);

    state_t             state_q, state_d;
    logic [3:0]         acq_cnt_q, acq_cnt_d;
    logic [3:0]         ring_q;
    logic [1:0]         phase_q, phase_d;
    logic [ROT_W-1:0]   rot_cnt_q, rot_cnt_d;
    logic               rot_pulse_q, rot_pulse_d;
    logic               err_sticky_q, err_sticky_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [3:0]         exp_ring;
    logic               onehot;
    logic               good;
    logic [1:0]         enc_idx;
    logic               enc_valid;
    logic               err_set;
    logic [1:0]         err_new;

    onehot4_enc u_enc (
        .onehot_i (RING),
        .idx_o    (enc_idx),
        .valid_o  (enc_valid)
    );

    // A step is good only if it is the previous sample rotated left by one.
    assign exp_ring = rotl4(ring_q);
    assign onehot   = is_onehot4(RING);
    assign good     = onehot && (RING == exp_ring);

    always_comb begin
        state_d     = state_q;
        acq_cnt_d   = acq_cnt_q;
        rot_cnt_d   = rot_cnt_q;
        rot_pulse_d = 1'b0;
        err_set     = 1'b0;
        err_new     = ERR_NONE;

        case (state_q)
            ST_SYNC: begin
                if (RING == RING_HOME) begin
                    state_d   = ST_ACQ;
                    acq_cnt_d = 4'd0;
                end
            end
            ST_ACQ: begin
                if (good) begin
                    acq_cnt_d = acq_cnt_q + 4'd1;
                    if (acq_cnt_q == LOCK_LAST) begin
                        state_d   = ST_LOCKED;
                        rot_cnt_d = '0;
                    end
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_LOCKED: begin
                if (good) begin
                    if (RING == RING_HOME) begin
                        rot_cnt_d   = rot_cnt_q + ROT_W'(1);
                        rot_pulse_d = 1'b1;
                    end
                end else begin
                    state_d = ST_FAULT;
                    err_set = 1'b1;
                    err_new = onehot ? ERR_ORDER : ERR_ONEHOT;
                end
            end
            ST_FAULT: state_d = ST_SYNC;
            default:  state_d = ST_SYNC;
        endcase

        // A fresh fault takes precedence over a simultaneous clear.
        err_sticky_d = err_sticky_q;
        err_code_d   = err_code_q;
        if (err_set) begin
            err_sticky_d = 1'b1;
            err_code_d   = err_new;
        end else if (CLR_ERR) begin
            err_sticky_d = 1'b0;
            err_code_d   = ERR_NONE;
        end

        phase_d = enc_valid ? enc_idx : phase_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_SYNC;
            acq_cnt_q    <= 4'd0;
            ring_q       <= 4'b0000;
            phase_q      <= 2'd0;
            rot_cnt_q    <= '0;
            rot_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            acq_cnt_q    <= acq_cnt_d;
            ring_q       <= RING;
            phase_q      <= phase_d;
            rot_cnt_q    <= rot_cnt_d;
            rot_pulse_q  <= rot_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_code_q   <= err_code_d;
        end
    end

    assign LOCKED     = (state_q == ST_LOCKED);
    assign PHASE      = phase_q;
    assign ROT_CNT    = rot_cnt_q;
    assign ROT_PULSE  = rot_pulse_q;
    assign ERR_STICKY = err_sticky_q;
    assign ERR_CODE   = err_code_q;

endmodule
